seg_reader: RTL and testbench
=============================

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the number of idle cycles without an accepted digit before a partial frame is discarded.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port seg_in, input, 7, active-low segments of a multiplexed display, bit 6 = a through bit 0 = g.
REQ-006 SHALL have port an_in, input, 4, active-low digit select; bit n low selects digit n.
REQ-007 SHALL have port value, output, 16, the last complete frame; digit n occupies bits 4n+3..4n.
REQ-008 SHALL have port frame_valid, output, 1, a one-cycle pulse when value, err and blank update.
REQ-009 SHALL have port err, output, 4, per-digit flag: the captured pattern was not a legal hex glyph.
REQ-010 SHALL have port blank, output, 4, per-digit flag: the captured pattern was all segments off (7'b1111111).
REQ-011 SHALL have port stale, output, 1, a one-cycle pulse when a partial frame is discarded by timeout.

Function
REQ-012 SHALL register seg_in and an_in once (sample stage) before any other use; all latencies below count from the sample register.
REQ-013 SHALL treat a sample as a candidate only when the sampled an_in has exactly one bit low; zero or multiple low bits clear the stability counter.
REQ-014 SHALL increment an 8-bit stability counter while the current candidate sample (seg and an) equals the previous sample, and reset it to 1 on any change; the counter saturates.
REQ-015 SHALL accept the digit in the cycle the counter reaches STABLE_CYCLES, exactly once per stable period; re-arm only after seg or an changes.
REQ-016 SHALL decode the glyphs 0..F with the inverse of the team's standard encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-017 SHALL store any other pattern as nibble 0 with its err bit set; all-off stores nibble 0 with its blank bit set, and its err bit clear.
REQ-018 SHALL keep a 4-bit seen mask; an accepted digit sets its bit, and a re-accepted digit overwrites its stored nibble and flags.
REQ-019 SHALL use the FSM COLLECT -> EMIT -> COLLECT; COLLECT moves to EMIT when the seen mask becomes 4'b1111.
REQ-020 In EMIT, SHALL copy the shadow nibbles and flags to value, err and blank, pulse frame_valid for one cycle, and clear the seen mask.
REQ-021 In EMIT, SHALL record a digit accepted in that same cycle into the cleared mask for the next frame, not lose it.
REQ-022 SHALL count idle cycles in COLLECT with a non-zero mask; at TIMEOUT_CYCLES it SHALL clear the mask, pulse stale, and leave value unchanged.
REQ-023 SHALL reset the idle counter on each accepted digit.
REQ-024 SHALL leave value, err and blank holding between frames.

Reset
REQ-025 With rst high at a clock edge, SHALL produce value=0, err=0, blank=0, frame_valid=0, stale=0, with the seen mask, counters and sample registers cleared and the FSM in COLLECT.
REQ-026 Reset mid-frame SHALL discard the partial frame, with no frame_valid and no stale pulse.

Structure
REQ-027 SHALL have a package seg_pkg that holds the 16-entry glyph table constant, the all-off constant, and the FSM state enum, shared with the display encoder.
REQ-028 SHALL have one combinational sub-module, seg_glyph_dec (7-bit pattern in; nibble, err, blank out), built from the seg_pkg table.

Verification
REQ-029 Digits 0..3 = 3,A,0,F, each held 6 cycles -> one frame_valid; value=16'hF0A3, err=0, blank=0.
REQ-030 Digit 1 held only 3 cycles (STABLE_CYCLES=4) then the scan continues -> no frame until digit 1 is held for 4 or more cycles.
REQ-031 Digit 2 = 7'b1111110 -> frame with err=4'b0100 and nibble 2 = 0; digit 3 = 7'b1111111 -> blank=4'b1000.
REQ-032 an_in = 4'b0000 or 4'b1010 for 10 cycles -> no accept and no frame.
REQ-033 Digits 0..2 captured, then idle for TIMEOUT_CYCLES (set to 20) -> stale pulse, value unchanged, and the next full scan yields a correct frame.
REQ-034 rst asserted after 2 digits are captured -> outputs 0, no pulses; a subsequent full scan yields exactly one frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph table (active-low, a..g = bit 6..0),
// the all-off pattern and the frame-assembly FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;

  // Index n holds the active-low segment pattern that displays hex digit n.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational inverse of the glyph table: pattern -> nibble plus err/blank flags.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b1;
    blank_o  = 1'b0;
    if (seg_i == SEG_ALL_OFF) begin
      err_o   = 1'b0;
      blank_o = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg_i == GLYPH_TABLE[i]) begin
          nibble_o = 4'(i);
          err_o    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_reader.sv
// Recovers a 4-digit hex frame by snooping a multiplexed seven-segment display:
// debounce each digit, collect all four, then publish value/err/blank together.
module seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  err,
  output logic [3:0]  blank,
  output logic        stale,
  output seg_state_e  state_dbg
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]  seg_q, prev_seg_q;
  logic [3:0]  an_q, prev_an_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] nib_q, nib_d;
  logic [3:0]  sh_err_q, sh_err_d, sh_blank_q, sh_blank_d;
  logic [IW-1:0] idle_q, idle_d;
  seg_state_e  state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d, blank_q, blank_d;
  logic        fv_q, fv_d, stale_q, stale_d;

  logic        candidate, same, accept;
  logic [1:0]  dig_idx;
  logic [3:0]  dig_bit;
  logic [3:0]  dec_nib;
  logic        dec_err, dec_blank;

  seg_glyph_dec u_dec (
    .seg_i    (seg_q),
    .nibble_o (dec_nib),
    .err_o    (dec_err),
    .blank_o  (dec_blank)
  );

  // Debounce: a digit is taken once, on the sample where the run length hits STABLE_CYCLES.
  always_comb begin
    candidate = $onehot(~an_q);
    same      = (seg_q == prev_seg_q) && (an_q == prev_an_q);
    cnt_d     = 8'd1;
    if (!candidate)
      cnt_d = 8'd0;
    else if (same && cnt_q != 8'd0)
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    accept  = candidate && same && (cnt_q == 8'(STABLE_CYCLES - 1));
    dig_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_q[i]) dig_idx = 2'(i);
    end
    dig_bit = 4'b0001 << dig_idx;
  end

  always_comb begin
    nib_d      = nib_q;
    sh_err_d   = sh_err_q;
    sh_blank_d = sh_blank_q;
    if (accept) begin
      nib_d[4*dig_idx +: 4] = dec_nib;
      sh_err_d[dig_idx]     = dec_err;
      sh_blank_d[dig_idx]   = dec_blank;
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    idle_d  = idle_q;
    value_d = value_q;
    err_d   = err_q;
    blank_d = blank_q;
    fv_d    = 1'b0;
    stale_d = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept) seen_d = seen_q | dig_bit;
        if (accept || seen_q == 4'h0) begin
          idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          idle_d  = '0;
          seen_d  = 4'h0;
          stale_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        if (seen_d == 4'hF) begin
          state_d = ST_EMIT;
          idle_d  = '0;
        end
      end
      ST_EMIT: begin
        // Shadow regs still hold the completed frame; a same-cycle accept starts the next one.
        value_d = nib_q;
        err_d   = sh_err_q;
        blank_d = sh_blank_q;
        fv_d    = 1'b1;
        seen_d  = accept ? dig_bit : 4'h0;
        idle_d  = '0;
        state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      an_q       <= '0;
      prev_seg_q <= '0;
      prev_an_q  <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      nib_q      <= '0;
      sh_err_q   <= '0;
      sh_blank_q <= '0;
      idle_q     <= '0;
      state_q    <= ST_COLLECT;
      value_q    <= '0;
      err_q      <= '0;
      blank_q    <= '0;
      fv_q       <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      seg_q      <= seg_in;
      an_q       <= an_in;
      prev_seg_q <= seg_q;
      prev_an_q  <= an_q;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      nib_q      <= nib_d;
      sh_err_q   <= sh_err_d;
      sh_blank_q <= sh_blank_d;
      idle_q     <= idle_d;
      state_q    <= state_d;
      value_q    <= value_d;
      err_q      <= err_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      stale_q    <= stale_d;
    end
  end

  assign value       = value_q;
  assign err         = err_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: scans digits onto the snooped bus and checks
// published frames, error/blank flags, timeout discard and reset behaviour.
module tb_seg_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  err;
  logic [3:0]  blank;
  logic        stale;
  logic [0:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int frame_cnt = 0;
  int stale_cnt = 0;
  int f0, s0;

  localparam logic [6:0] G [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] OFF = 7'b1111111;

  seg_reader #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value       (value),
    .frame_valid (frame_valid),
    .err         (err),
    .blank       (blank),
    .stale       (stale),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid === 1'b1) frame_cnt++;
    if (stale === 1'b1) stale_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive digit idx with pattern seg for n clock cycles.
  task automatic hold(input int idx, input logic [6:0] seg, input int n);
    an_in  = ~(4'b0001 << idx);
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_raw(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold_raw(4'b1111, OFF, n);
  endtask

  initial begin
    rst = 1'b1;
    seg_in = OFF;
    an_in = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    idle(2);

    // Basic frame 3,A,0,F.
    f0 = frame_cnt;
    hold(0, G[3], 6); hold(1, G[10], 6); hold(2, G[0], 6); hold(3, G[15], 6);
    idle(4);
    check("basic_frames", 32'(frame_cnt - f0), 32'd1);
    check("basic_value", 32'(value), 32'hF0A3);
    check("basic_err", 32'(err), 32'h0);
    check("basic_blank", 32'(blank), 32'h0);

    // Digit 1 too short: no frame until it is held long enough.
    f0 = frame_cnt;
    hold(0, G[1], 6); hold(1, G[2], 3); hold(2, G[5], 6); hold(3, G[8], 6);
    idle(3);
    check("short_noframe", 32'(frame_cnt - f0), 32'd0);
    check("short_value_held", 32'(value), 32'hF0A3);
    hold(1, G[2], 5);
    idle(3);
    check("short_frames", 32'(frame_cnt - f0), 32'd1);
    check("short_value", 32'(value), 32'h8521);

    // Illegal and all-off glyphs.
    f0 = frame_cnt;
    hold(0, G[1], 6); hold(1, G[2], 6); hold(2, 7'b1111110, 6); hold(3, OFF, 6);
    idle(4);
    check("flag_frames", 32'(frame_cnt - f0), 32'd1);
    check("flag_value", 32'(value), 32'h0021);
    check("flag_err", 32'(err), 32'h4);
    check("flag_blank", 32'(blank), 32'h8);

    // Zero or multiple selects must never be accepted.
    f0 = frame_cnt;
    s0 = stale_cnt;
    hold_raw(4'b0000, G[8], 10);
    hold_raw(4'b1010, G[8], 10);
    idle(3);
    check("multi_noframe", 32'(frame_cnt - f0), 32'd0);
    check("multi_nostale", 32'(stale_cnt - s0), 32'd0);

    // Partial frame discarded by timeout; output frame holds.
    hold(0, G[4], 6); hold(1, G[5], 6); hold(2, G[6], 6);
    idle(2);
    check("partial_noframe", 32'(frame_cnt - f0), 32'd0);
    idle(10);
    check("timeout_early", 32'(stale_cnt - s0), 32'd0);
    idle(15);
    check("timeout_stale", 32'(stale_cnt - s0), 32'd1);
    check("timeout_value", 32'(value), 32'h0021);
    check("timeout_err", 32'(err), 32'h4);
    check("timeout_noframe", 32'(frame_cnt - f0), 32'd0);
    hold(0, G[9], 6); hold(1, G[11], 6); hold(2, G[12], 6); hold(3, G[13], 6);
    idle(4);
    check("after_to_frames", 32'(frame_cnt - f0), 32'd1);
    check("after_to_value", 32'(value), 32'hDCB9);
    check("after_to_err", 32'(err), 32'h0);

    // Reset mid-frame.
    f0 = frame_cnt;
    s0 = stale_cnt;
    hold(0, G[1], 6); hold(1, G[2], 6);
    rst = 1'b1;
    idle(2);
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_blank", 32'(blank), 32'h0);
    check("midrst_fv", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    idle(30);
    check("midrst_noframe", 32'(frame_cnt - f0), 32'd0);
    check("midrst_nostale", 32'(stale_cnt - s0), 32'd0);
    hold(0, G[14], 6); hold(1, G[15], 6); hold(2, G[7], 6); hold(3, G[3], 6);
    idle(4);
    check("midrst_frames", 32'(frame_cnt - f0), 32'd1);
    check("midrst_newvalue", 32'(value), 32'h37FE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
